clarvi_soc_leds_pio: RTL



---
 rtl/clarvi_leds_pkg.sv | 14 +
 rtl/clarvi_leds_tick_div.sv | 28 ++
 rtl/clarvi_soc_leds_pio.sv | 128 ++++++++++++
 3 files changed

// File: rtl/clarvi_leds_pkg.sv
// Shared constants for the clarvi_soc LED PIO slave.
// Register word addresses and duty-cycle encodings.
package clarvi_leds_pkg;

  localparam logic [2:0] ADDR_DATA  = 3'd0;
  localparam logic [2:0] ADDR_DUTY  = 3'd1;
  localparam logic [2:0] ADDR_SET   = 3'd2;
  localparam logic [2:0] ADDR_CLR   = 3'd3;
  localparam logic [2:0] ADDR_BLINK = 3'd4;

  localparam logic [7:0] DUTY_FULL  = 8'hFF;
  localparam logic [7:0] DUTY_RESET = 8'hFF;

endpackage

// File: rtl/clarvi_leds_tick_div.sv
// Modulo-N free-running counter; wrap is high on the last count (N-1).
// Ports: clk, reset (async high), wrap (1-cycle pulse every N clocks).
module clarvi_leds_tick_div #(
  parameter int unsigned N = 4
) (
  input  logic clk,
  input  logic reset,
  output logic wrap
);

  localparam int W = (N > 1) ? $clog2(N) : 1;
  localparam logic [W-1:0] LAST = W'(N - 1);

  logic [W-1:0] cnt;

  assign wrap = (cnt == LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (wrap) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/clarvi_soc_leds_pio.sv
// Avalon-MM LED output PIO: data reg with set/clear aliases, PWM gate,
// optional blink mask (define CLARVI_LEDS_BLINK_EN).
// Ports: clk, reset, address[2:0], write, writedata[31:0],
//        readdata[31:0] (registered), out_port[WIDTH-1:0] (registered).
module clarvi_soc_leds_pio
  import clarvi_leds_pkg::*;
#(
  parameter int          WIDTH     = 16,
  parameter int unsigned PWM_DIV   = 4,
  parameter int unsigned BLINK_DIV = 25000000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [2:0]       address,
  input  logic             write,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  output logic [WIDTH-1:0] out_port
);

  logic [WIDTH-1:0] data;
  logic [7:0]       duty;
  logic [7:0]       pwm_cnt;
  logic             pwm_tick;
  logic             pwm_on;
  logic [WIDTH-1:0] wd;
  logic [WIDTH-1:0] blink_off_mask;
  logic [WIDTH-1:0] blink_rd;
  logic [31:0]      rd_next;

  assign wd = writedata[WIDTH-1:0];

  logic unused_wd;
  assign unused_wd = ^writedata;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data <= '0;
      duty <= DUTY_RESET;
    end else if (write) begin
      case (address)
        ADDR_DATA: data <= wd;
        ADDR_DUTY: duty <= writedata[7:0];
        ADDR_SET:  data <= data | wd;
        ADDR_CLR:  data <= data & ~wd;
        default:   ;
      endcase
    end
  end

  clarvi_leds_tick_div #(
    .N(PWM_DIV)
  ) u_pwm_div (
    .clk  (clk),
    .reset(reset),
    .wrap (pwm_tick)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pwm_cnt <= '0;
    end else if (pwm_tick) begin
      pwm_cnt <= pwm_cnt + 8'd1;
    end
  end

  // Full duty is forced on; otherwise 255/256 would be the ceiling.
  assign pwm_on = (duty == DUTY_FULL) | (pwm_cnt < duty);

`ifdef CLARVI_LEDS_BLINK_EN
  logic [WIDTH-1:0] blink_mask;
  logic             blink_phase;
  logic             blink_tick;

  clarvi_leds_tick_div #(
    .N(BLINK_DIV)
  ) u_blink_div (
    .clk  (clk),
    .reset(reset),
    .wrap (blink_tick)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      blink_mask <= '0;
    end else if (write && address == ADDR_BLINK) begin
      blink_mask <= wd;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      blink_phase <= 1'b0;
    end else if (blink_tick) begin
      blink_phase <= ~blink_phase;
    end
  end

  assign blink_off_mask = blink_mask & {WIDTH{blink_phase}};
  assign blink_rd       = blink_mask;
`else
  logic unused_blink_div;
  assign unused_blink_div = ^BLINK_DIV;
  assign blink_off_mask   = '0;
  assign blink_rd         = '0;
`endif

  always_comb begin
    rd_next = '0;
    case (address)
      ADDR_DATA:  rd_next = 32'(data);
      ADDR_DUTY:  rd_next = 32'(duty);
      ADDR_BLINK: rd_next = 32'(blink_rd);
      default:    rd_next = '0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      readdata <= '0;
      out_port <= '0;
    end else begin
      readdata <= rd_next;
      out_port <= data & {WIDTH{pwm_on}} & ~blink_off_mask;
    end
  end

endmodule
